// File: rtl/sm_matrix_arbiter.sv
// sm_matrix_arbiter
// -----------------
// Shares the single memory-matrix port between the instruction-fetch
// requester (m0) and the load/store requester (m1). One transfer is
// granted at a time with round-robin priority on ties. The owner's
// address, write flag and write data are forwarded to the matrix. The
// matrix response is routed back to the owner only. A watchdog
// abandons any transfer that the matrix never completes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   m0_*/m1_*                requester side:
//                              a, we, wd, valid  (in)
//                              ready, rd, err    (out)
//   s_a, s_we, s_wd, s_valid request to the matrix (out)
//   s_ready, s_rd            matrix completion / read data (in)
//   grant                    one-hot owner (bit0=m0, bit1=m1), 00 when idle
//   busy                     a transfer is in progress
//
// Parameters
//   ADDR_W, DATA_W           address / data widths
//   TIMEOUT                  max BUSY cycles waiting for s_ready
//                            (0 disables the watchdog, max 65535)
module sm_matrix_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_a,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic              m0_valid,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rd,
    output logic              m0_err,

    input  logic [ADDR_W-1:0] m1_a,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic              m1_valid,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rd,
    output logic              m1_err,

    output logic [ADDR_W-1:0] s_a,
    output logic              s_we,
    output logic [DATA_W-1:0] s_wd,
    output logic              s_valid,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rd,

    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Watchdog fires in the TIMEOUT-th BUSY cycle, i.e. when the count
    // of stalled cycles already seen equals TIMEOUT-1.
    localparam bit          TMO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    logic [0:0]  state;
    logic        owner;
    logic        last;
    logic [15:0] wcnt;

    logic        win;
    logic        active;
    logic        tmo_hit;
    logic        done;
    logic        timed_out;

    // Tie goes to the requester not served last; otherwise whoever asks.
    assign win = (m0_valid && m1_valid) ? ~last : m1_valid;

    // Everything the block drives is held quiet while rst is high, so an
    // interrupted transfer can never complete during the reset cycle.
    assign active    = (state == BUSY) && !rst;
    assign tmo_hit   = TMO_EN && (wcnt == TMO_LAST);
    // A real completion beats a simultaneous watchdog expiry.
    assign done      = active && (s_ready || tmo_hit);
    assign timed_out = done && !s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            wcnt  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state <= BUSY;
                        owner <= win;
                        wcnt  <= 16'd0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                        last  <= owner;
                    end else begin
                        wcnt <= wcnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_a      = '0;
        s_we     = 1'b0;
        s_wd     = '0;
        s_valid  = 1'b0;
        grant    = 2'b00;
        m0_ready = 1'b0;
        m0_rd    = '0;
        m0_err   = 1'b0;
        m1_ready = 1'b0;
        m1_rd    = '0;
        m1_err   = 1'b0;

        if (active) begin
            s_valid = 1'b1;
            if (owner) begin
                s_a   = m1_a;
                s_we  = m1_we;
                s_wd  = m1_wd;
                grant = 2'b10;
            end else begin
                s_a   = m0_a;
                s_we  = m0_we;
                s_wd  = m0_wd;
                grant = 2'b01;
            end
        end

        // Response path is purely combinational; read data is forced to
        // zero on a watchdog completion.
        if (done) begin
            if (owner) begin
                m1_ready = 1'b1;
                m1_err   = timed_out;
                m1_rd    = timed_out ? '0 : s_rd;
            end else begin
                m0_ready = 1'b1;
                m0_err   = timed_out;
                m0_rd    = timed_out ? '0 : s_rd;
            end
        end
    end

    assign busy = active;

endmodule

// File: tb/tb_sm_matrix_arbiter.sv
module tb_sm_matrix_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_a, m1_a, m0_wd, m1_wd, s_rd;
    logic        m0_we, m1_we, m0_valid, m1_valid, s_ready;

    // Main instance (watchdog long enough for the wait-state test)
    logic        m0_ready, m0_err, m1_ready, m1_err, s_we, s_valid, busy;
    logic [31:0] m0_rd, m1_rd, s_a, s_wd;
    logic [1:0]  grant;

    // Short-watchdog instance (TIMEOUT=4)
    logic        t_m0_ready, t_m0_err, t_m1_ready, t_m1_err, t_s_we, t_s_valid, t_busy;
    logic [31:0] t_m0_rd, t_m1_rd, t_s_a, t_s_wd;
    logic [1:0]  t_grant;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    always #5 clk = ~clk;

    sm_matrix_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd), .m0_valid(m0_valid),
        .m0_ready(m0_ready), .m0_rd(m0_rd), .m0_err(m0_err),
        .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd), .m1_valid(m1_valid),
        .m1_ready(m1_ready), .m1_rd(m1_rd), .m1_err(m1_err),
        .s_a(s_a), .s_we(s_we), .s_wd(s_wd), .s_valid(s_valid),
        .s_ready(s_ready), .s_rd(s_rd), .grant(grant), .busy(busy)
    );

    sm_matrix_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd), .m0_valid(m0_valid),
        .m0_ready(t_m0_ready), .m0_rd(t_m0_rd), .m0_err(t_m0_err),
        .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd), .m1_valid(m1_valid),
        .m1_ready(t_m1_ready), .m1_rd(t_m1_rd), .m1_err(t_m1_err),
        .s_a(t_s_a), .s_we(t_s_we), .s_wd(t_s_wd), .s_valid(t_s_valid),
        .s_ready(s_ready), .s_rd(s_rd), .grant(t_grant), .busy(t_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; new inputs applied here
    // are seen at the following edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        m0_a = '0; m1_a = '0; m0_wd = '0; m1_wd = '0; s_rd = '0;
        m0_we = 1'b0; m1_we = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

        // ---------------- reset state
        next();
        settle();
        chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_grant",   {30'd0, grant},   32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        next();
        rst = 1'b0;
        settle();
        chk("post_rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("post_rst_m0_ready", {31'd0, m0_ready}, 32'd0);

        // ---------------- single m0 read
        m0_valid = 1'b1; m0_a = 32'h0000_0010; m0_we = 1'b0;
        settle();
        chk("t1_c0_s_valid", {31'd0, s_valid}, 32'd0);
        next();
        settle();
        chk("t1_c1_s_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_c1_s_a",     s_a,              32'h0000_0010);
        chk("t1_c1_grant",   {30'd0, grant},   32'd1);
        s_ready = 1'b1; s_rd = 32'h1234_5678;
        settle();
        chk("t1_m0_ready", {31'd0, m0_ready}, 32'd1);
        chk("t1_m0_rd",    m0_rd,             32'h1234_5678);
        chk("t1_m0_err",   {31'd0, m0_err},   32'd0);
        chk("t1_m1_ready", {31'd0, m1_ready}, 32'd0);
        chk("t1_m1_rd",    m1_rd,             32'd0);
        next();
        m0_valid = 1'b0; s_ready = 1'b0;
        settle();
        chk("t1_c2_grant",    {30'd0, grant},    32'd0);
        chk("t1_c2_m0_ready", {31'd0, m0_ready}, 32'd0);

        // ---------------- simultaneous requests after reset: 0,1,0,1
        rst = 1'b1;
        next();
        rst = 1'b0;
        m0_valid = 1'b1; m0_a = 32'h0000_0100;
        m1_valid = 1'b1; m1_a = 32'h0000_0200;
        s_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_rd = 32'hA5A5_0000 + k;
            next();
            settle();
            chk("t2_grant",    {30'd0, grant},    (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_s_a",      s_a,               (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("t2_m0_ready", {31'd0, m0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_m1_ready", {31'd0, m1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("t2_m0_rd",    m0_rd,             (k % 2 == 0) ? 32'hA5A5_0000 + k : 32'd0);
            chk("t2_m1_rd",    m1_rd,             (k % 2 == 0) ? 32'd0 : 32'hA5A5_0000 + k);
            next();
            if (k == 3) begin
                m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
            end
            settle();
            chk("t2_idle_grant", {30'd0, grant}, 32'd0);
        end

        // ---------------- m1 write with 5 wait states
        m1_valid = 1'b1; m1_we = 1'b1; m1_wd = 32'hCAFE_BABE; m1_a = 32'h2000_0004;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            next();
            s_ready = (i == 6);
            s_rd = 32'h5555_AAAA;
            settle();
            chk("t3_s_we",   {31'd0, s_we},   32'd1);
            chk("t3_s_wd",   s_wd,            32'hCAFE_BABE);
            chk("t3_s_a",    s_a,             32'h2000_0004);
            chk("t3_grant",  {30'd0, grant},  32'd2);
            chk("t3_m1_ready", {31'd0, m1_ready}, (i == 6) ? 32'd1 : 32'd0);
            chk("t3_m1_err", {31'd0, m1_err}, 32'd0);
            if (m1_ready) pulses++;
        end
        next();
        m1_valid = 1'b0; m1_we = 1'b0; s_ready = 1'b0;
        settle();
        if (m1_ready) pulses++;
        chk("t3_pulses",     pulses,         32'd1);
        chk("t3_idle_grant", {30'd0, grant}, 32'd0);

        // ---------------- timeout, TIMEOUT=4
        rst = 1'b1;
        next();
        rst = 1'b0;
        m0_valid = 1'b1; m0_a = 32'h0000_0040; m0_we = 1'b0;
        s_ready = 1'b0; s_rd = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            next();
            settle();
            chk("t4_busy",     {31'd0, t_busy},     32'd1);
            chk("t4_m0_ready", {31'd0, t_m0_ready}, (i == 4) ? 32'd1 : 32'd0);
            chk("t4_m0_err",   {31'd0, t_m0_err},   (i == 4) ? 32'd1 : 32'd0);
            chk("t4_m0_rd",    t_m0_rd,             32'd0);
        end
        next();
        m0_valid = 1'b0;
        s_ready = 1'b1;   // late completion of the abandoned transfer
        settle();
        chk("t4_after_busy",  {31'd0, t_busy},     32'd0);
        chk("t4_after_grant", {30'd0, t_grant},    32'd0);
        chk("t4_late_ready",  {31'd0, t_m0_ready}, 32'd0);
        next();
        s_ready = 1'b0;

        // ---------------- timeout collides with s_ready
        rst = 1'b1;
        next();
        rst = 1'b0;
        m0_valid = 1'b1; m0_a = 32'h0000_0044;
        for (int i = 1; i <= 4; i++) begin
            next();
            s_ready = (i == 4);
            s_rd = 32'h0BAD_F00D;
            settle();
        end
        chk("t5_m0_ready", {31'd0, t_m0_ready}, 32'd1);
        chk("t5_m0_err",   {31'd0, t_m0_err},   32'd0);
        chk("t5_m0_rd",    t_m0_rd,             32'h0BAD_F00D);
        next();
        m0_valid = 1'b0; s_ready = 1'b0;
        settle();
        chk("t5_idle_grant", {30'd0, t_grant}, 32'd0);

        // ---------------- reset in the middle of a transfer
        // last is now m0, so without the reset a tie would go to m1.
        m1_valid = 1'b1; m1_a = 32'h0000_0300; m1_we = 1'b0;
        next();
        settle();
        chk("t6_c1_grant", {30'd0, grant}, 32'd2);
        next();
        rst = 1'b1;
        settle();
        chk("t6_rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        next();
        rst = 1'b0;
        m1_valid = 1'b0;
        s_ready = 1'b1;
        settle();
        chk("t6_s_valid", {31'd0, s_valid},  32'd0);
        chk("t6_grant",   {30'd0, grant},    32'd0);
        chk("t6_m1_ready", {31'd0, m1_ready}, 32'd0);
        s_ready = 1'b0;
        m0_valid = 1'b1; m0_a = 32'h0000_0500;
        m1_valid = 1'b1; m1_a = 32'h0000_0600;
        next();
        settle();
        chk("t6_tie_grant", {30'd0, grant}, 32'd1);
        chk("t6_tie_s_a",   s_a,            32'h0000_0500);
        m0_valid = 1'b0; m1_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
